// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int MAX_N = 16;

  function automatic logic [3:0] onehot2idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_interconnect_arb_wrr_if.sv
// rtl/wb_interconnect_arb_wrr_if.sv - request/grant bundle between bus masters and the arbiter
interface wb_interconnect_arb_wrr_if #(
  parameter int N  = 4,
  parameter int QW = 4
);
  logic [N-1:0]         req_i;
  logic                 ack_i;
  logic [N*QW-1:0]      quota_i;
  logic [N-1:0]         gnt_o;
  logic [$clog2(N)-1:0] gnt_idx_o;
  logic                 gnt_valid_o;
  logic                 timeout_o;

  modport slave (
    input  req_i, ack_i, quota_i,
    output gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
  );

  modport master (
    output req_i, ack_i, quota_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
  );
endinterface

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - round-robin priority picker, search starts at ptr+1
module wb_arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [$clog2(N)-1:0] ptr,
  input  logic [N-1:0]         elig,
  output logic [N-1:0]         win,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW-1:0]  start;
  logic [2*N-1:0] dbl_in;
  logic [2*N-1:0] dbl_out;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;

  assign start = (ptr == IW'(N - 1)) ? '0 : ptr + IW'(1);

  // Rotate so the search origin lands on bit 0, isolate the lowest set bit, rotate back.
  assign dbl_in  = {elig, elig} >> start;
  assign rot     = dbl_in[N-1:0];
  assign first   = rot & (-rot);
  assign dbl_out = {first, first} << start;
  assign win     = dbl_out[2*N-1:N];
  assign any     = |elig;

endmodule

// File: rtl/wb_interconnect_arb_wrr.sv
// rtl/wb_interconnect_arb_wrr.sv - weighted round-robin bus-cycle arbiter with hang watchdog
module wb_interconnect_arb_wrr
  import wb_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int QW      = 4,
  parameter int TW      = 8,
  parameter int TIMEOUT = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  wb_interconnect_arb_wrr_if.slave  bus
);
  localparam int            IW      = $clog2(N);
  localparam bit            WD_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  blk_q, blk_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [QW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          tmo_q, tmo_d;
  logic          valid_q;

  logic [N-1:0]  elig;
  logic [N-1:0]  pick;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic [QW-1:0] quota_sel;
  logic          stay;

  assign elig      = bus.req_i & ~blk_q;
  assign stay      = elig[ptr_q] && (cnt_q != '0);
  assign pick_idx  = IW'(onehot2idx(MAX_N'(pick)));
  assign quota_sel = bus.quota_i[pick_idx*QW +: QW];

  wb_arb_rr_pick #(.N(N)) u_pick (
    .ptr  (ptr_q),
    .elig (elig),
    .win  (pick),
    .any  (pick_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      blk_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      valid_q <= |gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    tmo_d   = 1'b0;
    // A block lifts only once its master has been seen idle for a cycle.
    blk_d   = blk_q & bus.req_i;
    case (state_q)
      IDLE: begin
        if (stay) begin
          state_d        = OWN;
          gnt_d          = '0;
          gnt_d[ptr_q]   = 1'b1;
          idx_d          = ptr_q;
          cnt_d          = cnt_q - QW'(1);
          wd_d           = '0;
        end else if (pick_any) begin
          state_d = OWN;
          gnt_d   = pick;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = (quota_sel == '0) ? '0 : quota_sel - QW'(1);
          wd_d    = '0;
        end
      end
      OWN: begin
        if (tmo_q) begin
          // The err cycle has been delivered; evict and fence off the hung master.
          state_d      = IDLE;
          gnt_d        = '0;
          blk_d[idx_q] = 1'b1;
          cnt_d        = '0;
          wd_d         = '0;
        end else if (!bus.req_i[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          wd_d    = '0;
        end else if (bus.ack_i) begin
          wd_d = '0;
        end else begin
          wd_d  = wd_q + TW'(1);
          tmo_d = WD_EN && (wd_q == WD_LAST);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = valid_q;
  assign bus.timeout_o   = tmo_q;

endmodule
